// File: rtl/pdm_pkg.sv
// Shared constants and types for the PDM sample streamer: register map,
// status/control bit positions and the drain FSM state type.
package pdm_pkg;

  localparam logic [1:0] REG_FIFO = 2'd0;
  localparam logic [1:0] REG_DIV  = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_UNF   = 3;
  localparam int ST_LATE  = 4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_CLR   = 2;

  typedef enum logic {IDLE, BUSY} fsm_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; level carries one extra bit so a
// completely full FIFO (level == DEPTH) is representable.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers wrap for free because DEPTH is a power of two.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pdm_sample_streamer.sv
// CPU-fed sample FIFO drained at a programmable rate as single Wishbone writes
// (address = channel, data = sample) toward the PDM peripheral.
module pdm_sample_streamer
  import pdm_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int DIV_W    = 16,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_stb,
  input  logic            s_we,
  input  logic [1:0]      s_adr,
  input  logic [31:0]     s_dat_c,
  output logic [31:0]     s_dat_p,
  output logic            s_ack,
  output logic            m_stb,
  output logic            m_we,
  output logic [CH_W-1:0] m_adr,
  output logic [BITS-1:0] m_dat,
  input  logic            m_ack
);

  localparam int EW = BITS + CH_W;
  localparam int LW = $clog2(DEPTH) + 1;

  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [EW-1:0]    fifo_wdata, fifo_rdata;
  logic [LW-1:0]    fifo_level;

  logic             enable_q, enable_d, tick_pend_q, tick_pend_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, late_q, late_d;
  logic             s_ack_q, s_ack_d;
  logic [DIV_W-1:0] div_reload_q, div_reload_d, div_cnt_q, div_cnt_d;
  logic [31:0]      s_dat_p_q, s_dat_p_d, status;
  logic             bus_wr, ctrl_wr, clr, tick, launch, underflow;

  fsm_state_e       state_q;
  logic             m_stb_q;
  logic [CH_W-1:0]  m_adr_q;
  logic [BITS-1:0]  m_dat_q;

  logic unused_dat;
  assign unused_dat = ^s_dat_c[31:16+CH_W];

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    bus_wr     = s_stb & s_we;
    ctrl_wr    = bus_wr && (s_adr == REG_CTRL);
    fifo_push  = bus_wr && (s_adr == REG_FIFO);
    fifo_flush = ctrl_wr & s_dat_c[CTRL_FLUSH];
    clr        = ctrl_wr & s_dat_c[CTRL_CLR];
    fifo_wdata = {s_dat_c[16 +: CH_W], s_dat_c[0 +: BITS]};

    tick      = enable_q && (div_cnt_q == '0);
    // A flush in the launch cycle empties the FIFO, so nothing is popped.
    launch    = (state_q == IDLE) && tick_pend_q && !fifo_empty && !fifo_flush;
    underflow = (state_q == IDLE) && tick_pend_q && fifo_empty;
    fifo_pop  = launch;

    enable_d     = ctrl_wr ? s_dat_c[CTRL_EN] : enable_q;
    div_reload_d = (bus_wr && (s_adr == REG_DIV)) ? s_dat_c[DIV_W-1:0] : div_reload_q;
    if (!enable_q || tick) div_cnt_d = div_reload_q;
    else                   div_cnt_d = div_cnt_q - DIV_W'(1);

    tick_pend_d = tick_pend_q;
    if (launch || underflow) tick_pend_d = 1'b0;
    if (tick)                tick_pend_d = 1'b1;

    // Sticky flags: a set event in the clear cycle survives the clear.
    ovf_d  = clr ? 1'b0 : ovf_q;
    unf_d  = clr ? 1'b0 : unf_q;
    late_d = clr ? 1'b0 : late_q;
    if (fifo_push && fifo_full) ovf_d  = 1'b1;
    if (underflow)              unf_d  = 1'b1;
    if (tick && tick_pend_q)    late_d = 1'b1;

    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = ovf_q;
    status[ST_UNF]   = unf_q;
    status[ST_LATE]  = late_q;
    status[15:8]     = 8'(fifo_level);

    s_ack_d   = s_stb;
    s_dat_p_d = '0;
    if (s_stb) begin
      case (s_adr)
        REG_FIFO: s_dat_p_d = status;
        REG_DIV:  s_dat_p_d = 32'(div_reload_q);
        REG_CTRL: s_dat_p_d = {31'b0, enable_q};
        default:  s_dat_p_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q     <= 1'b0;
      div_reload_q <= '0;
      div_cnt_q    <= '0;
      tick_pend_q  <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      late_q       <= 1'b0;
      s_ack_q      <= 1'b0;
      s_dat_p_q    <= '0;
    end else begin
      enable_q     <= enable_d;
      div_reload_q <= div_reload_d;
      div_cnt_q    <= div_cnt_d;
      tick_pend_q  <= tick_pend_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      late_q       <= late_d;
      s_ack_q      <= s_ack_d;
      s_dat_p_q    <= s_dat_p_d;
    end
  end

  // Drain FSM: outputs are held stable from launch until the peripheral acks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_stb_q <= 1'b0;
      m_adr_q <= '0;
      m_dat_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (launch) begin
          m_stb_q <= 1'b1;
          m_adr_q <= fifo_rdata[BITS +: CH_W];
          m_dat_q <= fifo_rdata[0 +: BITS];
          state_q <= BUSY;
        end
        BUSY: if (m_ack) begin
          m_stb_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_ack   = s_ack_q;
  assign s_dat_p = s_dat_p_q;
  assign m_stb   = m_stb_q;
  assign m_we    = 1'b1;
  assign m_adr   = m_adr_q;
  assign m_dat   = m_dat_q;

endmodule
